freq_meas_scheduler: RTL
========================

// Module: freq_meas_scheduler
// PURPOSE
//  Time-shares one equal-precision frequency counter core among NCH measured clocks.
//  - Selects the core's clk_fx source through an external mux (ch_sel).
//  - Holds the core in reset to settle, then runs it for a fixed window.
//  - Samples its 64-bit fre result and publishes it per channel.
//  - Sits between the clk_fs reference domain and the counter core; all logic runs on clk_fs.
// PARAMETERS
//  NCH          4      number of measured channels (2..16)
//  SETTLE_CYC   8      clk_fs cycles core_rst_n held low after a channel switch
//  MEAS_CYC     50000  clk_fs cycles core runs before fre is sampled (>= core gate + sync margin)
//  STABLE_CYC   16     clk_fs cycles between the two stability samples (FMS_STABLE_CHECK_EN only)
//  MAX_RETRY    2      extra measurement windows allowed on mismatch (FMS_STABLE_CHECK_EN only)
// PORTS
//  clk_fs      in   1              reference clock; all state on rising edge
//  rst_n       in   1              async active-low reset
//  run_en      in   1              level; 1 = keep scheduling enabled channels
//  ch_en       in   NCH            per-channel enable mask, sampled when choosing the next channel
//  core_fre    in   64             result from counter core
//  core_rst_n  out  1              reset to counter core (active-low, registered)
//  ch_sel      out  clog2(NCH)     clk_fx mux select, registered
//  busy        out  1              1 in any state except IDLE
//  res_valid   out  1              1-cycle pulse: res_ch/res_fre/res_err valid
//  res_ch      out  clog2(NCH)     channel of the published result
//  res_fre     out  64             published frequency
//  res_err     out  1              1 = stability check failed after all retries
//  rd_ch       in   clog2(NCH)     readback select (combinational)
//  rd_fre      out  64             last published fre of channel rd_ch
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, core_rst_n=0, ch_sel=0, busy=0, res_valid=0, res_ch=0, res_fre=0, res_err=0.
//   - All per-channel result registers and the round-robin pointer = 0.
//  FSM:
//   - IDLE: if run_en & |ch_en -> SEL. Otherwise remain in IDLE, core_rst_n=0.
//   - SEL: ch_sel <= next enabled channel, searched round-robin from ptr+1 with wrap NCH-1 -> 0.
//     The first selection after reset starts the search at channel 0. core_rst_n=0. -> SETTLE.
//   - SETTLE: core_rst_n=0 for SETTLE_CYC cycles -> MEAS.
//   - MEAS: core_rst_n=1 and count MEAS_CYC cycles. Window counter is 32 bits, reloaded on entry.
//     -> CAPT.
//   - CAPT: sample core_fre. Next cycle: res_valid=1 with res_ch=ch_sel, res_fre=sample,
//     and per-channel register[ch_sel] updated. -> NEXT.
//   - NEXT: ptr <= ch_sel. If run_en & |ch_en -> SEL, else -> IDLE.
//  Boundary rules:
//   - ch_en changing mid-measurement has no effect on the current channel. The result is
//     still published even if that channel's enable is now cleared.
//   - run_en low mid-measurement: finish the current channel, then IDLE. There is no abort.
//   - A single enabled channel is re-measured back-to-back, passing through SEL/SETTLE each time.
//   - Latency per channel = 1(SEL) + SETTLE_CYC + MEAS_CYC + 1(CAPT) + 1(NEXT) cycles.
//   - rst_n asserted mid-operation: immediate return to all reset values. A partial result is
//     never published.
//   - core_fre is used as-is; the core must hold it stable at sample time. 64-bit, no arithmetic.
// CONFIGURATION
//  FMS_STABLE_CHECK_EN defined:
//   - CAPT takes sample A, waits STABLE_CYC cycles with core_rst_n=1, then takes sample B.
//   - A==B: publish A with res_err=0.
//   - A!=B: re-enter MEAS without re-settling, incrementing a retry count that is cleared in SEL.
//   - After MAX_RETRY failed retries: publish B with res_err=1.
//  FMS_STABLE_CHECK_EN not defined:
//   - Single sample; res_err is tied 0. STABLE_CYC and MAX_RETRY are unused.
// TESTING  (NCH=4, SETTLE_CYC=4, MEAS_CYC=1000, STABLE_CYC=16, MAX_RETRY=2; clk_fs 20 ns period)
//  1. Reset, then run_en=1, ch_en=4'b1111, with a core model returning 1000+ch.
//     -> res_valid pulses for ch 0,1,2,3,0 in order, 1007 cycles apart; rd_fre[2]=1002.
//  2. ch_en=4'b0101. -> channel order 0,2,0,2; ch_sel never equals 1 or 3.
//  3. Deassert run_en 300 cycles into MEAS on ch1.
//     -> ch1 result still published; busy=0 two cycles later; core_rst_n=0.
//  4. Assert rst_n=0 during MEAS. -> immediately busy=0, core_rst_n=0, res_valid=0;
//     rd_fre for all channels reads 0.
//  5. ch_en=0 with run_en=1. -> FSM stays IDLE, no res_valid pulse over 5000 cycles.
//  6. With FMS_STABLE_CHECK_EN: model fre toggles between samples on ch3.
//     -> three windows on ch3, then res_err=1 with res_fre equal to sample B;
//     stable channels report res_err=0.

Source files
------------

// File: rtl/freq_meas_scheduler.sv
// Time-shares one frequency counter core across NCH measured clocks on the clk_fs domain.
// Optional FMS_STABLE_CHECK_EN: double-sample fre and retry the window on mismatch.
module freq_meas_scheduler #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned MEAS_CYC   = 50000,
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic                   clk_fs,
    input  logic                   rst_n,
    input  logic                   run_en,
    input  logic [NCH-1:0]         ch_en,
    input  logic [63:0]            core_fre,
    output logic                   core_rst_n,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic                   busy,
    output logic                   res_valid,
    output logic [$clog2(NCH)-1:0] res_ch,
    output logic [63:0]            res_fre,
    output logic                   res_err,
    input  logic [$clog2(NCH)-1:0] rd_ch,
    output logic [63:0]            rd_fre
);

    localparam int unsigned CW = $clog2(NCH);
    localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] MEAS_LD   = 32'(MEAS_CYC - 1);

    if (NCH < 2 || NCH > 16 || SETTLE_CYC == 0 || MEAS_CYC == 0 ||
        STABLE_CYC == 0 || MAX_RETRY > 255) begin : g_bad_cfg
        $error("freq_meas_scheduler: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SETTLE, S_MEAS, S_CAPT, S_STAB, S_NEXT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_cnt, w_cnt_nxt;
    logic [CW-1:0]   r_ptr, w_ptr_nxt;
    logic            r_first, w_first_nxt;
    logic [CW-1:0]   r_ch_sel, w_ch_sel_nxt;
    logic            r_core_rst_n, w_core_rst_n_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_res_valid, w_res_valid_nxt;
    logic [CW-1:0]   r_res_ch, w_res_ch_nxt;
    logic [63:0]     r_res_fre, w_res_fre_nxt;
    logic            r_res_err, w_res_err_nxt;
    logic            w_pub;
    logic [63:0]     r_fre_mem [NCH];

    logic [CW-1:0]   w_start, w_idx, w_pick;
    logic            w_found;

`ifdef FMS_STABLE_CHECK_EN
    localparam logic [31:0] STABLE_LD = 32'(STABLE_CYC - 1);
    logic [63:0]     r_samp_a, w_samp_a_nxt;
    logic [7:0]      r_retry, w_retry_nxt;
`endif

    // Round-robin pick: first enabled channel at or after ptr+1 (channel 0 after reset)
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        w_start = '0;
        if (!r_first && (32'(r_ptr) != NCH - 1)) begin
            w_start = CW'(r_ptr + CW'(1));
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            w_idx = CW'((32'(w_start) + i) % NCH);
            if (!w_found && ch_en[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_ptr;
        w_first_nxt     = r_first;
        w_ch_sel_nxt    = r_ch_sel;
        w_res_valid_nxt = 1'b0;
        w_res_ch_nxt    = r_res_ch;
        w_res_fre_nxt   = r_res_fre;
        w_res_err_nxt   = r_res_err;
        w_pub           = 1'b0;
`ifdef FMS_STABLE_CHECK_EN
        w_samp_a_nxt    = r_samp_a;
        w_retry_nxt     = r_retry;
`endif
        case (r_state)
            S_IDLE: begin
                if (run_en && (|ch_en)) w_state_nxt = S_SEL;
            end
            S_SEL: begin
                if (w_found) begin
                    w_ch_sel_nxt = w_pick;
                    w_cnt_nxt    = SETTLE_LD;
                    w_state_nxt  = S_SETTLE;
`ifdef FMS_STABLE_CHECK_EN
                    w_retry_nxt  = '0;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = MEAS_LD;
                    w_state_nxt = S_MEAS;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            S_MEAS: begin
                if (r_cnt == '0) w_state_nxt = S_CAPT;
                else             w_cnt_nxt   = r_cnt - 32'd1;
            end
            S_CAPT: begin
`ifdef FMS_STABLE_CHECK_EN
                w_samp_a_nxt = core_fre;
                w_cnt_nxt    = STABLE_LD;
                w_state_nxt  = S_STAB;
`else
                w_pub         = 1'b1;
                w_res_fre_nxt = core_fre;
                w_res_err_nxt = 1'b0;
                w_state_nxt   = S_NEXT;
`endif
            end
            S_STAB: begin
`ifdef FMS_STABLE_CHECK_EN
                // Sample B: publish when stable, else rerun the window while retries remain
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end else if (core_fre == r_samp_a) begin
                    w_pub         = 1'b1;
                    w_res_fre_nxt = r_samp_a;
                    w_res_err_nxt = 1'b0;
                    w_state_nxt   = S_NEXT;
                end else if (r_retry < 8'(MAX_RETRY)) begin
                    w_retry_nxt = r_retry + 8'd1;
                    w_cnt_nxt   = MEAS_LD;
                    w_state_nxt = S_MEAS;
                end else begin
                    w_pub         = 1'b1;
                    w_res_fre_nxt = core_fre;
                    w_res_err_nxt = 1'b1;
                    w_state_nxt   = S_NEXT;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_NEXT: begin
                w_ptr_nxt   = r_ch_sel;
                w_first_nxt = 1'b0;
                w_state_nxt = (run_en && (|ch_en)) ? S_SEL : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_pub) begin
            w_res_valid_nxt = 1'b1;
            w_res_ch_nxt    = r_ch_sel;
        end

        w_core_rst_n_nxt = (w_state_nxt == S_MEAS) || (w_state_nxt == S_CAPT) ||
                           (w_state_nxt == S_STAB);
        w_busy_nxt       = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_first      <= 1'b1;
            r_ch_sel     <= '0;
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_ch     <= '0;
            r_res_fre    <= '0;
            r_res_err    <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) r_fre_mem[i] <= '0;
`ifdef FMS_STABLE_CHECK_EN
            r_samp_a     <= '0;
            r_retry      <= '0;
`endif
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_first      <= w_first_nxt;
            r_ch_sel     <= w_ch_sel_nxt;
            r_core_rst_n <= w_core_rst_n_nxt;
            r_busy       <= w_busy_nxt;
            r_res_valid  <= w_res_valid_nxt;
            r_res_ch     <= w_res_ch_nxt;
            r_res_fre    <= w_res_fre_nxt;
            r_res_err    <= w_res_err_nxt;
            if (w_pub) r_fre_mem[r_ch_sel] <= w_res_fre_nxt;
`ifdef FMS_STABLE_CHECK_EN
            r_samp_a     <= w_samp_a_nxt;
            r_retry      <= w_retry_nxt;
`endif
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign ch_sel     = r_ch_sel;
    assign busy       = r_busy;
    assign res_valid  = r_res_valid;
    assign res_ch     = r_res_ch;
    assign res_fre    = r_res_fre;
    assign res_err    = r_res_err;
    assign rd_fre     = (32'(rd_ch) < NCH) ? r_fre_mem[rd_ch] : '0;

endmodule
